fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares the single-port 640x480 pixel frame memory between three requesters:
  - the VGA display fetch path (read-only, latency-critical);
  - two writer clients (image loader = wr0, overlay/stat painter = wr1).
- Display has default priority. The writers share the leftover slots round-robin.
- An anti-starvation counter per writer forces a write slot when a writer has waited too long.
- Sits between the pixel-fetch logic driven by vga_sync and the frame RAM. Owns the RAM address, write-enable and write-data pins.

Parameters:
- AW, 19, frame memory address width.
- DW, 24, pixel word width ({R,G,B} 8 bits each).
- FRAME, 307200, number of valid pixel addresses (640*480).
- MAX_WAIT, 16, wait cycles after which a pending writer preempts the display (legal range 1..255).

Ports:
- clk  in  1  system pixel-domain clock
- RST  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request, sampled every cycle
- disp_addr  in  AW  display read address
- disp_rdata  out  DW  read data returned to display
- disp_rvalid  out  1  disp_rdata valid pulse
- disp_drop  out  1  pulse: the display request of 1 cycle earlier was preempted
- wr0_req, wr1_req  in  1  write request, held until granted
- wr0_addr, wr1_addr  in  AW  write address
- wr0_data, wr1_data  in  DW  write data
- wr0_gnt, wr1_gnt  out  1  one-cycle grant pulse
- addr_err  out  1  pulse: a granted access had address >= FRAME
- drop_cnt  out  16  saturating count of display drops
- mem_addr  out  AW  registered RAM address
- mem_we  out  1  registered RAM write enable
- mem_wdata  out  DW  registered RAM write data
- mem_rdata  in  DW  synchronous RAM read data, valid 1 cycle after mem_addr

Behaviour:
- Reset:
  - RST is asynchronous and active-high. Assertion clears everything immediately, including mid-operation.
  - The following are 0 on reset: all outputs, mem_addr, mem_we, mem_wdata, wait counters, drop_cnt, and the read pipeline flags. Any in-flight read is flushed and produces no rvalid.
  - Round-robin pointer resets to "last = wr1", so wr0 wins the first writer tie.
- Arbitration timing:
  - Requests are sampled at cycle t. The winner is registered onto mem_* and *_gnt/disp_drop at the edge ending t. These signals are visible during t+1.
  - Display read data: disp_rdata = mem_rdata with disp_rvalid = 1 during t+2. disp_rdata holds its last value otherwise.
- Eligibility:
  - A writer is eligible if its req is high AND its gnt is not high in the current cycle. This masks the stale req during the grant cycle.
  - Requesters drop or replace req/addr/data in the cycle after gnt.
- Priority, evaluated each cycle:
  1. Any eligible writer whose wait counter == MAX_WAIT (starved). If both are starved, round-robin decides.
  2. disp_req.
  3. Eligible writers, round-robin (the writer not granted last wins a tie).
  4. Idle: mem_we = 0, mem_addr holds its previous value.
- Display preempted by a starved writer:
  - disp_drop = 1 in t+1 and no rvalid for that request.
  - drop_cnt increments and saturates at 0xFFFF.
- Wait counters, one per writer (8 bits):
  - Increment when eligible and not granted, saturating at MAX_WAIT.
  - Clear on grant or when req is low.
- Write grant:
  - mem_we = 1, mem_addr/mem_wdata = writer's addr/data, wrN_gnt = 1 for exactly one cycle.
  - Round-robin pointer updates only on write grants.
- Address range error:
  - Any granted access with addr >= FRAME: addr_err pulses in t+1.
  - For writes, mem_we is forced to 0 but gnt still pulses (the request completes).
  - For reads, disp_rvalid still fires with whatever mem_rdata returns.
- Back-to-back display requests are served every cycle with no bubbles while no writer is starved.

Test Plan:
- Reset behaviour: assert RST mid-transfer with a read in flight -> all outputs 0 immediately, no disp_rvalid after release; first tie grants wr0.
- Display read latency: disp_req=1, disp_addr=0x00005 alone for 1 cycle -> mem_addr=5, mem_we=0 at t+1; disp_rvalid=1 at t+2 with disp_rdata = RAM[5].
- Writer round-robin: display idle, wr0_req and wr1_req held high continuously with distinct data -> grants alternate wr0,wr1,wr0,...; each gnt is 1 cycle; RAM contents match; no double write per request.
- Starvation: disp_req held high continuously, wr1_req high from cycle 0 -> wr1_gnt at cycle MAX_WAIT+1 (17); disp_drop=1 in the same cycle; drop_cnt=1; display resumes the next cycle.
- Address error: wr0_addr=307200 -> wr0_gnt pulses, addr_err=1, mem_we=0, RAM unchanged; disp_addr=307199 -> no addr_err.
- Drop counter saturation: force 65540 starvation preemptions (or preload via bench force) -> drop_cnt sticks at 0xFFFF.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-memory port arbiter: display reads have priority, writers share leftover slots round-robin, starved writers preempt the display.
// Latency: requests sampled in cycle t drive mem_*/gnt/drop/addr_err in t+1; display read data returns in t+2.
// Backpressure: writers hold req until a one-cycle gnt pulse; the display is never stalled, only dropped (disp_drop) when a starved writer takes its slot.
// Ports: clk/RST; disp_req/disp_addr -> disp_rdata/disp_rvalid/disp_drop; wrN_req/addr/data -> wrN_gnt;
//        addr_err/drop_cnt status; mem_addr/mem_we/mem_wdata drive the RAM, mem_rdata returns from it.
module fb_port_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 24,
    parameter int FRAME    = 307200,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    output logic          disp_drop,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr0_gnt,
    output logic          wr1_gnt,
    output logic          addr_err,
    output logic [15:0]   drop_cnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            AW1     = AW + 1;
    localparam logic [AW:0]   FRAME_L = AW1'(FRAME);
    localparam logic [7:0]    MAX_W   = 8'(MAX_WAIT);

    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic          mem_we_q,    mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          wr0_gnt_q,   wr0_gnt_d;
    logic          wr1_gnt_q,   wr1_gnt_d;
    logic          drop_q,      drop_d;
    logic          addr_err_q,  addr_err_d;
    logic [15:0]   drop_cnt_q,  drop_cnt_d;
    logic [7:0]    wait0_q,     wait0_d;
    logic [7:0]    wait1_q,     wait1_d;
    logic          last_wr1_q,  last_wr1_d;
    logic          rd1_q,       rd1_d;       // read address on the RAM pins
    logic          rd2_q,       rd2_d;       // RAM data for that read is on mem_rdata
    logic [DW-1:0] rdata_hold_q, rdata_hold_d;

    logic          elig0, elig1, starve0, starve1;
    logic          pick0, pick1, pick_rd, preempt;
    logic [AW-1:0] sel_addr;
    logic          sel_err;

    always_comb begin
        // A writer's req is stale during its own grant cycle, so mask it there.
        elig0   = wr0_req & ~wr0_gnt_q;
        elig1   = wr1_req & ~wr1_gnt_q;
        starve0 = elig0 && (wait0_q == MAX_W);
        starve1 = elig1 && (wait1_q == MAX_W);

        pick0   = 1'b0;
        pick1   = 1'b0;
        pick_rd = 1'b0;
        preempt = 1'b0;
        if (starve0 || starve1) begin
            preempt = disp_req;
            if (starve0 && starve1) begin
                pick0 = last_wr1_q;
                pick1 = ~last_wr1_q;
            end else begin
                pick0 = starve0;
                pick1 = starve1;
            end
        end else if (disp_req) begin
            pick_rd = 1'b1;
        end else if (elig0 && elig1) begin
            // The writer not granted last wins the tie.
            pick0 = last_wr1_q;
            pick1 = ~last_wr1_q;
        end else begin
            pick0 = elig0;
            pick1 = elig1;
        end

        sel_addr = disp_addr;
        if (pick0) sel_addr = wr0_addr;
        if (pick1) sel_addr = wr1_addr;
        sel_err = (pick0 || pick1 || pick_rd) && ({1'b0, sel_addr} >= FRAME_L);

        // Idle cycles leave the RAM address where it was.
        mem_addr_d  = (pick0 || pick1 || pick_rd) ? sel_addr : mem_addr_q;
        // Out-of-range writes still complete (gnt) but never touch the RAM.
        mem_we_d    = (pick0 || pick1) && !sel_err;
        mem_wdata_d = pick0 ? wr0_data : (pick1 ? wr1_data : mem_wdata_q);
        wr0_gnt_d   = pick0;
        wr1_gnt_d   = pick1;
        drop_d      = preempt;
        addr_err_d  = sel_err;
        last_wr1_d  = pick1 ? 1'b1 : (pick0 ? 1'b0 : last_wr1_q);
        rd1_d       = pick_rd;
        rd2_d       = rd1_q;
        rdata_hold_d = rd2_q ? mem_rdata : rdata_hold_q;

        drop_cnt_d = drop_cnt_q;
        if (preempt && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

        if (!wr0_req || pick0 || wr0_gnt_q) wait0_d = 8'd0;
        else if (wait0_q != MAX_W)          wait0_d = wait0_q + 8'd1;
        else                                wait0_d = wait0_q;

        if (!wr1_req || pick1 || wr1_gnt_q) wait1_d = 8'd0;
        else if (wait1_q != MAX_W)          wait1_d = wait1_q + 8'd1;
        else                                wait1_d = wait1_q;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            wr0_gnt_q    <= 1'b0;
            wr1_gnt_q    <= 1'b0;
            drop_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            drop_cnt_q   <= 16'd0;
            wait0_q      <= 8'd0;
            wait1_q      <= 8'd0;
            last_wr1_q   <= 1'b1;
            rd1_q        <= 1'b0;
            rd2_q        <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            wr0_gnt_q    <= wr0_gnt_d;
            wr1_gnt_q    <= wr1_gnt_d;
            drop_q       <= drop_d;
            addr_err_q   <= addr_err_d;
            drop_cnt_q   <= drop_cnt_d;
            wait0_q      <= wait0_d;
            wait1_q      <= wait1_d;
            last_wr1_q   <= last_wr1_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr0_gnt     = wr0_gnt_q;
    assign wr1_gnt     = wr1_gnt_q;
    assign disp_drop   = drop_q;
    assign addr_err    = addr_err_q;
    assign drop_cnt    = drop_cnt_q;
    assign disp_rvalid = rd2_q;
    // Synchronous RAM data is passed straight through in its valid cycle, held afterwards.
    assign disp_rdata  = rd2_q ? mem_rdata : rdata_hold_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
`timescale 1ns/1ps
module tb_fb_port_arbiter;
    localparam int AW = 19, DW = 24, FRAME = 307200, MAX_WAIT = 16;

    logic          clk = 1'b0;
    logic          RST;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid, disp_drop;
    logic          wr0_req, wr1_req;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_gnt, wr1_gnt, addr_err;
    logic [15:0]   drop_cnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;

    typedef struct packed {
        logic          id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic [DW-1:0] rd_q[$];
    wr_exp_t       wr_q[$];

    fb_port_arbiter #(.AW(AW), .DW(DW), .FRAME(FRAME), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .RST(RST),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .disp_rvalid(disp_rvalid), .disp_drop(disp_drop),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt), .addr_err(addr_err), .drop_cnt(drop_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Background RAM contents: a bijective pattern of the address, overlaid by a write log.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = DW'(a);
        return (v * 24'd37) ^ 24'hC35A96;
    endfunction

    logic [AW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];
    int            wr_n = 0;

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = pat(a);
        for (int i = 0; i < wr_n; i++) if (log_addr[i] == a) v = log_data[i];
        return v;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= ram_rd(mem_addr);
        if (mem_we && wr_n < 64) begin
            log_addr[wr_n] <= mem_addr;
            log_data[wr_n] <= mem_wdata;
            wr_n           <= wr_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 1'b0; disp_addr = '0;
        wr0_req  = 1'b0; wr0_addr  = '0; wr0_data = '0;
        wr1_req  = 1'b0; wr1_addr  = '0; wr1_data = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h we=%b wdata=%h, expected all 0", mem_addr, mem_we, mem_wdata);
        end
        checks++;
        if ({disp_rvalid, disp_drop, wr0_gnt, wr1_gnt, addr_err} !== 5'b0 || disp_rdata !== '0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: rv=%b drop=%b g0=%b g1=%b err=%b rdata=%h cnt=%h, expected all 0",
                     disp_rvalid, disp_drop, wr0_gnt, wr1_gnt, addr_err, disp_rdata, drop_cnt);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_read_latency();
        disp_req = 1'b1; disp_addr = AW'(5);
        rd_q.push_back(pat(AW'(5)));
        step();
        disp_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== AW'(5) || mem_we !== 1'b0 || disp_rvalid !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_t1: addr=%h we=%b rv=%b err=%b, expected addr=5 we=0 rv=0 err=0", mem_addr, mem_we, disp_rvalid, addr_err);
        end
        step();
        @(negedge clk);
        checks++;
        if (disp_rvalid !== 1'b1 || rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_t2_valid: rv=%b, expected 1", disp_rvalid);
        end else if (disp_rdata !== rd_q.pop_front()) begin
            errors++;
            $display("FAIL rd_t2_data: got %h, expected %h", disp_rdata, pat(AW'(5)));
        end
        step();
        @(negedge clk);
        checks++;
        if (disp_rvalid !== 1'b0 || disp_rdata !== pat(AW'(5))) begin
            errors++;
            $display("FAIL rd_hold: rv=%b rdata=%h, expected rv=0 rdata=%h", disp_rvalid, disp_rdata, pat(AW'(5)));
        end
        step();
    endtask

    task automatic test_back_to_back();
        int rv_seen = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                a = (c == 5) ? AW'(FRAME - 1) : AW'(200 + c);
                disp_req = 1'b1; disp_addr = a;
                rd_q.push_back(pat(a));
            end else begin
                disp_req = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (addr_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_err cycle %0d: addr_err=%b, expected 0", c, addr_err);
            end
            checks++;
            if (disp_rvalid !== (c >= 2 && c <= 9)) begin
                errors++;
                $display("FAIL b2b_bubble cycle %0d: rv=%b, expected %b", c, disp_rvalid, (c >= 2 && c <= 9));
            end
            if (disp_rvalid === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: rvalid with no read outstanding, expected none");
                end else begin
                    e = rd_q.pop_front();
                    rv_seen++;
                    if (disp_rdata !== e) begin
                        errors++;
                        $display("FAIL b2b_data: got %h, expected %h", disp_rdata, e);
                    end
                end
            end
            step();
        end
        checks++;
        if (rv_seen != 8 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: %0d rvalids, %0d left, expected 8 and 0", rv_seen, rd_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n0 = 0, n1 = 0, g0 = 0, g1 = 0;
        logic s0, s1;
        wr_exp_t e;
        wr0_req = 1'b1; wr0_addr = AW'(1000); wr0_data = DW'(32'h100000);
        wr_q.push_back({1'b0, wr0_addr, wr0_data}); n0++;
        wr1_req = 1'b1; wr1_addr = AW'(1001); wr1_data = DW'(32'h200000);
        wr_q.push_back({1'b1, wr1_addr, wr1_data}); n1++;
        for (int c = 0; c < 40 && (g0 < 6 || g1 < 6); c++) begin
            @(negedge clk);
            s0 = wr0_gnt; s1 = wr1_gnt;
            checks++;
            if (mem_we !== (s0 ^ s1)) begin
                errors++;
                $display("FAIL rr_we cycle %0d: we=%b g0=%b g1=%b, expected we with exactly one gnt", c, mem_we, s0, s1);
            end
            if (s0 || s1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra: grant g0=%b g1=%b with nothing expected", s0, s1);
                end else begin
                    e = wr_q.pop_front();
                    if ({s1, mem_addr, mem_wdata} !== {e.id, e.addr, e.data}) begin
                        errors++;
                        $display("FAIL rr_order: got wr%0d addr=%h data=%h, expected wr%0d addr=%h data=%h",
                                 s1, mem_addr, mem_wdata, e.id, e.addr, e.data);
                    end
                end
            end
            if (s0) g0++;
            if (s1) g1++;
            step();
            if (s0) begin
                if (n0 < 6) begin
                    wr0_addr = AW'(1000 + 2 * n0); wr0_data = DW'(32'h100000 + n0);
                    wr_q.push_back({1'b0, wr0_addr, wr0_data}); n0++;
                end else wr0_req = 1'b0;
            end
            if (s1) begin
                if (n1 < 6) begin
                    wr1_addr = AW'(1001 + 2 * n1); wr1_data = DW'(32'h200000 + n1);
                    wr_q.push_back({1'b1, wr1_addr, wr1_data}); n1++;
                end else wr1_req = 1'b0;
            end
        end
        wr0_req = 1'b0; wr1_req = 1'b0;
        step();
        checks++;
        if (g0 != 6 || g1 != 6 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL rr_count: g0=%0d g1=%0d left=%0d, expected 6 6 0", g0, g1, wr_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ram_rd(AW'(1000 + 2 * k)) !== DW'(32'h100000 + k) || ram_rd(AW'(1001 + 2 * k)) !== DW'(32'h200000 + k)) begin
                errors++;
                $display("FAIL rr_ram k=%0d: got %h/%h, expected %h/%h", k, ram_rd(AW'(1000 + 2 * k)),
                         ram_rd(AW'(1001 + 2 * k)), DW'(32'h100000 + k), DW'(32'h200000 + k));
            end
        end
    endtask

    task automatic test_starvation();
        int rv_seen = 0;
        logic s1;
        logic [DW-1:0] e;
        wr1_req = 1'b1; wr1_addr = AW'(3000); wr1_data = 24'h5EED01;
        for (int c = 0; c < 25; c++) begin
            if (c < 22) begin
                disp_req = 1'b1; disp_addr = AW'(400 + c);
                if (c != MAX_WAIT) rd_q.push_back(pat(AW'(400 + c)));
            end else disp_req = 1'b0;
            @(negedge clk);
            s1 = wr1_gnt;
            checks++;
            if (wr1_gnt !== (c == MAX_WAIT + 1) || disp_drop !== (c == MAX_WAIT + 1)) begin
                errors++;
                $display("FAIL starve_gnt cycle %0d: gnt=%b drop=%b, expected %b", c, wr1_gnt, disp_drop, (c == MAX_WAIT + 1));
            end
            if (c == MAX_WAIT + 1) begin
                exp_drops++;
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== AW'(3000) || mem_wdata !== 24'h5EED01 || drop_cnt !== 16'(exp_drops)) begin
                    errors++;
                    $display("FAIL starve_write: we=%b addr=%h data=%h cnt=%0d, expected 1 %h 5eed01 %0d",
                             mem_we, mem_addr, mem_wdata, drop_cnt, AW'(3000), exp_drops);
                end
            end
            if (c == MAX_WAIT + 2) begin
                checks++;
                if (mem_we !== 1'b0 || mem_addr !== AW'(400 + MAX_WAIT + 1)) begin
                    errors++;
                    $display("FAIL starve_resume: we=%b addr=%h, expected 0 %h", mem_we, mem_addr, AW'(400 + MAX_WAIT + 1));
                end
            end
            if (disp_rvalid === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL starve_extra: rvalid with no read outstanding");
                end else begin
                    e = rd_q.pop_front();
                    rv_seen++;
                    if (disp_rdata !== e) begin
                        errors++;
                        $display("FAIL starve_data: got %h, expected %h", disp_rdata, e);
                    end
                end
            end
            step();
            if (s1) wr1_req = 1'b0;
        end
        checks++;
        if (rv_seen != 21 || rd_q.size() != 0 || ram_rd(AW'(3000)) !== 24'h5EED01) begin
            errors++;
            $display("FAIL starve_summary: rv=%0d left=%0d ram=%h, expected 21 0 5eed01", rv_seen, rd_q.size(), ram_rd(AW'(3000)));
        end
    endtask

    task automatic test_addr_err();
        logic [DW-1:0] e;
        wr0_req = 1'b1; wr0_addr = AW'(FRAME); wr0_data = 24'hDEAD00;
        step();
        @(negedge clk);
        checks++;
        if (wr0_gnt !== 1'b1 || addr_err !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL aerr_write: gnt=%b err=%b we=%b, expected 1 1 0", wr0_gnt, addr_err, mem_we);
        end
        step();
        wr0_req = 1'b0;
        disp_req = 1'b1; disp_addr = AW'(FRAME - 1); rd_q.push_back(pat(AW'(FRAME - 1)));
        @(negedge clk);
        checks++;
        if (wr0_gnt !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL aerr_single: gnt=%b err=%b, expected 0 0", wr0_gnt, addr_err);
        end
        step();
        disp_addr = AW'(FRAME); rd_q.push_back(pat(AW'(FRAME)));
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL aerr_last_pixel: err=%b, expected 0", addr_err);
        end
        step();
        disp_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (addr_err !== (c == 0) || disp_rvalid !== 1'b1 || rd_q.size() == 0) begin
                errors++;
                $display("FAIL aerr_read %0d: err=%b rv=%b, expected err=%b rv=1", c, addr_err, disp_rvalid, (c == 0));
            end else begin
                e = rd_q.pop_front();
                if (disp_rdata !== e) begin
                    errors++;
                    $display("FAIL aerr_rdata %0d: got %h, expected %h", c, disp_rdata, e);
                end
            end
            step();
        end
        checks++;
        if (ram_rd(AW'(FRAME)) !== pat(AW'(FRAME))) begin
            errors++;
            $display("FAIL aerr_ram: got %h, expected %h", ram_rd(AW'(FRAME)), pat(AW'(FRAME)));
        end
    endtask

    task automatic test_drop_sat();
        logic seen;
        logic [15:0] exp_cnt;
        force dut.drop_cnt_q = 16'hFFFD;
        step();
        release dut.drop_cnt_q;
        @(negedge clk);
        checks++;
        if (drop_cnt !== 16'hFFFD) begin
            errors++;
            $display("FAIL sat_preload: got %h, expected fffd", drop_cnt);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            exp_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
            disp_req = 1'b1; disp_addr = AW'(600);
            wr1_req = 1'b1; wr1_addr = AW'(3100 + k); wr1_data = DW'(32'h600000 + k);
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (wr1_gnt === 1'b1) begin
                    seen = 1'b1;
                    checks++;
                    if (disp_drop !== 1'b1 || drop_cnt !== exp_cnt) begin
                        errors++;
                        $display("FAIL sat_cnt %0d: drop=%b cnt=%h, expected 1 %h", k, disp_drop, drop_cnt, exp_cnt);
                    end
                end
                step();
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL sat_timeout %0d: no preemption grant within 40 cycles, expected one", k);
            end
        end
        wr1_req = 1'b0; disp_req = 1'b0;
        repeat (3) step();
        rd_q.delete();
    endtask

    task automatic test_reset_midflight();
        wr0_req = 1'b1; wr0_addr = AW'(2000); wr0_data = 24'hABCDEF;
        step();
        disp_req = 1'b1; disp_addr = AW'(5);
        step();
        wr0_req = 1'b0; disp_req = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_we !== 1'b0 || drop_cnt !== 16'd0 ||
            {disp_rvalid, disp_drop, wr0_gnt, wr1_gnt, addr_err} !== 5'b0 || disp_rdata !== '0) begin
            errors++;
            $display("FAIL midreset_now: addr=%h wdata=%h we=%b cnt=%h rv=%b rdata=%h, expected all 0",
                     mem_addr, mem_wdata, mem_we, drop_cnt, disp_rvalid, disp_rdata);
        end
        @(posedge clk);
        #1 RST = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (disp_rvalid !== 1'b0 || disp_rdata !== '0) begin
                errors++;
                $display("FAIL midreset_flush %0d: rv=%b rdata=%h, expected 0 0", c, disp_rvalid, disp_rdata);
            end
            step();
        end
        wr0_req = 1'b1; wr0_addr = AW'(4000); wr0_data = 24'h0000A0;
        wr_q.push_back({1'b0, wr0_addr, wr0_data});
        wr1_req = 1'b1; wr1_addr = AW'(4001); wr1_data = 24'h0000B1;
        wr_q.push_back({1'b1, wr1_addr, wr1_data});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if ((wr0_gnt ^ wr1_gnt) !== 1'b1 || wr_q.size() == 0 ||
                    {wr1_gnt, mem_addr, mem_wdata} !== {wr_q[0].id, wr_q[0].addr, wr_q[0].data}) begin
                    errors++;
                    $display("FAIL tie_after_reset %0d: g0=%b g1=%b addr=%h, expected one grant in order wr0 then wr1",
                             c, wr0_gnt, wr1_gnt, mem_addr);
                end
                if (wr_q.size() != 0) void'(wr_q.pop_front());
            end
            step();
            if (c == 1) wr0_req = 1'b0;
            if (c == 2) wr1_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_back_to_back();
        test_round_robin();
        test_starvation();
        test_addr_err();
        test_drop_sat();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end

endmodule
